tri_raster: RTL and testbench
=============================

TRI_RASTER -- requirements
Module: tri_raster

Interface
REQ-001 SHALL have parameter W, default 12, coordinate width in bits (unsigned).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports p1X, p1Y, p2X, p2Y, p3X, p3Y  input  W each  triangle vertices.
REQ-005 SHALL have port in_valid  input  1  vertices valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a triangle.
REQ-007 SHALL have ports out_x, out_y  output  W each  coordinates of the current inside pixel.
REQ-008 SHALL have port out_valid  output  1  out_x/out_y hold an inside pixel.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the pixel.
REQ-010 SHALL have port done  output  1  one-cycle pulse at scan end.
REQ-011 SHALL have port pix_count  output  2W+1  inside pixels emitted for the last triangle.

Function
REQ-012 FSM SHALL have states IDLE, BBOX, SCAN, DONE; in_ready=1 only in IDLE.
REQ-013 Triangle SHALL be accepted on an edge with in_valid&&in_ready: vertices latched, pix_count cleared, next state BBOX.
REQ-014 BBOX (one cycle) SHALL register xmin/xmax/ymin/ymax of the three vertices, load cur=(xmin,ymin), then enter SCAN.
REQ-015 SCAN SHALL visit every point of the box exactly once, row-major: x ascending from xmin to xmax, then y+1 with x reset to xmin.
REQ-016 Edge value for edge (a,b) at point T SHALL be E=(Tx-bx)*(ay-by)-(ax-bx)*(Ty-by); differences 13-bit signed (W+1), products 2W+2 bits, E 2W+3 bits; no truncation.
REQ-017 Edges SHALL be (p1,p2), (p2,p3), (p3,p1); point inside iff all three E>=0 (boundary points included).
REQ-018 out_x/out_y SHALL equal cur; out_valid SHALL be 1 iff state==SCAN and cur inside; out_valid SHALL NOT depend combinationally on any input.
REQ-019 cur SHALL advance when cur is outside, or when out_valid&&out_ready; with out_valid=1 and out_ready=0, out_x/out_y/out_valid SHALL hold.
REQ-020 pix_count SHALL increment by 1 on each out_valid&&out_ready edge.
REQ-021 Throughput SHALL be one box point per cycle with out_ready held 1.
REQ-022 On advance from (xmax,ymax), FSM SHALL enter DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-023 Degenerate (collinear or coincident) vertices SHALL be scanned normally; a single-point box SHALL give one SCAN cycle.
REQ-024 in_valid while not in IDLE SHALL be ignored; vertex inputs SHALL be sampled only at acceptance.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, done=0, pix_count=0, out_x=out_y=0, at any point including mid-scan.
REQ-026 After rst_n release, a new triangle SHALL be acceptable on the first rising edge.

Configuration
REQ-027 Macro TRI_RASTER_BACKFACE_EN defined: point SHALL be inside iff all three E>=0 or all three E<=0 (either winding rasterised).
REQ-028 Macro TRI_RASTER_BACKFACE_EN undefined: only the REQ-017 rule SHALL apply; clockwise triangles yield only points with all E>=0.

Verification
REQ-029 Vertices (20,20),(40,20),(30,40), out_ready=1 -> first out (20,20) two cycles after acceptance; 21 pixels with y=20 (x=20..40); done pulses once; pix_count equals golden-model count.
REQ-030 Same triangle, out_ready=0 for 5 cycles when (20,20) appears -> out_valid, out_x=20, out_y=20 stable 5 cycles; next pixel (21,20) after out_ready=1.
REQ-031 Vertices (20,20),(30,40),(40,20) -> macro undefined: pix_count=0, done pulses; macro defined: pix_count equals REQ-029 count.
REQ-032 All vertices (7,7) -> exactly one pixel (7,7), pix_count=1, done pulse.
REQ-033 rst_n=0 mid-scan of REQ-029 triangle -> out_valid=0 immediately (async), in_ready=1, pix_count=0; a new triangle after release scans correctly.
REQ-034 Vertices (0,0),(4095,0),(0,4095) -> no overflow: (4095,0) and (0,4095) emitted, (4095,4095) not emitted.

Source files
------------

// File: rtl/tri_raster.sv
`default_nettype none
// ============================================================================
// Module   : tri_raster
// Purpose  : Scans the bounding box of a triangle in row-major order and
//            emits every box point that lies inside the triangle, using
//            three exact-width edge functions (boundary points included).
// Ports    : clk, rst_n (async active-low)
//            p1X/p1Y, p2X/p2Y, p3X/p3Y [W]  vertices, sampled on acceptance
//            in_valid / in_ready            triangle handshake
//            out_x/out_y [W], out_valid     current inside pixel
//            out_ready                      pixel consumer handshake
//            done                           one-cycle pulse at scan end
//            pix_count [2W+1]               pixels emitted for last triangle
// Options  : TRI_RASTER_BACKFACE_EN - when defined, points with all three
//            edge values <= 0 are also inside (either winding rasterised).
// Revision : 1.0 - initial release
// ============================================================================
module tri_raster #(
    parameter int W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   p1X,
    input  logic [W-1:0]   p1Y,
    input  logic [W-1:0]   p2X,
    input  logic [W-1:0]   p2Y,
    input  logic [W-1:0]   p3X,
    input  logic [W-1:0]   p3Y,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_x,
    output logic [W-1:0]   out_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           done,
    output logic [2*W:0]   pix_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BBOX = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [W-1:0] r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y;
    logic [W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [W-1:0] r_cur_x, r_cur_y;
    logic [2*W:0] r_pix_count;

    logic [W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic signed [2*W+2:0] w_e12, w_e23, w_e31;
    logic         w_inside;
    logic         w_advance;
    logic         w_last;
    logic         w_accept;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [W-1:0] min3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // E = (Tx-bx)*(ay-by) - (ax-bx)*(Ty-by). Differences are W+1 bits signed,
    // products 2W+2 bits, and the final subtraction gets one more bit so the
    // full range of unsigned W-bit coordinates never wraps.
    function automatic logic signed [2*W+2:0] edge_val(
        input logic [W-1:0] tx, input logic [W-1:0] ty,
        input logic [W-1:0] ax, input logic [W-1:0] ay,
        input logic [W-1:0] bx, input logic [W-1:0] by);
        logic signed [W:0]     d_tx, d_ay, d_ax, d_ty;
        logic signed [2*W+1:0] m0, m1;
        d_tx = $signed({1'b0, tx}) - $signed({1'b0, bx});
        d_ay = $signed({1'b0, ay}) - $signed({1'b0, by});
        d_ax = $signed({1'b0, ax}) - $signed({1'b0, bx});
        d_ty = $signed({1'b0, ty}) - $signed({1'b0, by});
        m0 = d_tx * d_ay;
        m1 = d_ax * d_ty;
        return $signed({m0[2*W+1], m0}) - $signed({m1[2*W+1], m1});
    endfunction

    // ------------------------------------------------------------------------
    // Combinational datapath (all from registered state)
    // ------------------------------------------------------------------------
    assign w_xmin = min3(r_v1x, r_v2x, r_v3x);
    assign w_xmax = max3(r_v1x, r_v2x, r_v3x);
    assign w_ymin = min3(r_v1y, r_v2y, r_v3y);
    assign w_ymax = max3(r_v1y, r_v2y, r_v3y);

    assign w_e12 = edge_val(r_cur_x, r_cur_y, r_v1x, r_v1y, r_v2x, r_v2y);
    assign w_e23 = edge_val(r_cur_x, r_cur_y, r_v2x, r_v2y, r_v3x, r_v3y);
    assign w_e31 = edge_val(r_cur_x, r_cur_y, r_v3x, r_v3y, r_v1x, r_v1y);

`ifdef TRI_RASTER_BACKFACE_EN
    assign w_inside = (!w_e12[2*W+2] && !w_e23[2*W+2] && !w_e31[2*W+2]) ||
                      ((w_e12[2*W+2] || (w_e12 == '0)) &&
                       (w_e23[2*W+2] || (w_e23 == '0)) &&
                       (w_e31[2*W+2] || (w_e31 == '0)));
`else
    assign w_inside = !w_e12[2*W+2] && !w_e23[2*W+2] && !w_e31[2*W+2];
`endif

    assign in_ready  = (r_state == IDLE);
    assign done      = (r_state == DONE);
    assign out_valid = (r_state == SCAN) && w_inside;
    assign out_x     = r_cur_x;
    assign out_y     = r_cur_y;
    assign pix_count = r_pix_count;

    assign w_accept  = in_valid && (r_state == IDLE);
    // Outside points are skipped without waiting on the consumer.
    assign w_advance = (r_state == SCAN) && (!w_inside || out_ready);
    assign w_last    = (r_cur_x == r_xmax) && (r_cur_y == r_ymax);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = BBOX;
            BBOX:    w_next_state = SCAN;
            SCAN:    if (w_advance && w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1x       <= '0;
            r_v1y       <= '0;
            r_v2x       <= '0;
            r_v2y       <= '0;
            r_v3x       <= '0;
            r_v3y       <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_pix_count <= '0;
        end else begin
            if (w_accept) begin
                r_v1x       <= p1X;
                r_v1y       <= p1Y;
                r_v2x       <= p2X;
                r_v2y       <= p2Y;
                r_v3x       <= p3X;
                r_v3y       <= p3Y;
                r_pix_count <= '0;
            end

            if (r_state == BBOX) begin
                r_xmin  <= w_xmin;
                r_xmax  <= w_xmax;
                r_ymin  <= w_ymin;
                r_ymax  <= w_ymax;
                r_cur_x <= w_xmin;
                r_cur_y <= w_ymin;
            end

            if (w_advance) begin
                if (r_cur_x == r_xmax) begin
                    r_cur_x <= r_xmin;
                    if (r_cur_y != r_ymax) begin
                        r_cur_y <= r_cur_y + 1'b1;
                    end
                end else begin
                    r_cur_x <= r_cur_x + 1'b1;
                end
            end

            if (out_valid && out_ready) begin
                r_pix_count <= r_pix_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tri_raster.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_raster
// Purpose  : Self-checking bench for tri_raster. Stimulus pushes expected
//            pixels into a scoreboard queue; a monitor pops and compares each
//            accepted pixel. Totals are hand-derived constants.
// Options  : TRI_RASTER_BACKFACE_EN changes the clockwise-triangle result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_raster;

    localparam int W = 12;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   p1X, p1Y, p2X, p2Y, p3X, p3Y;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_x, out_y;
    logic           out_valid;
    logic           out_ready;
    logic           done;
    logic [2*W:0]   pix_count;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [2*W-1:0] sb[$];

    tri_raster #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p1X       (p1X),
        .p1Y       (p1Y),
        .p2X       (p2X),
        .p2Y       (p2Y),
        .p3X       (p3X),
        .p3Y       (p3Y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .pix_count (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: walks the box row-major for at most max_pts points and
    // queues every inside pixel.
    function automatic int model(input int ax, input int ay, input int bx,
                                 input int by, input int cx, input int cy,
                                 input int max_pts);
        int xmin, xmax, ymin, ymax, n, cnt;
        longint e1, e2, e3;
        bit in_pos, in_neg;
        xmin = ax; if (bx < xmin) xmin = bx; if (cx < xmin) xmin = cx;
        xmax = ax; if (bx > xmax) xmax = bx; if (cx > xmax) xmax = cx;
        ymin = ay; if (by < ymin) ymin = by; if (cy < ymin) ymin = cy;
        ymax = ay; if (by > ymax) ymax = by; if (cy > ymax) ymax = cy;
        n = 0;
        cnt = 0;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                if (n < max_pts) begin
                    e1 = longint'(x - bx) * longint'(ay - by) - longint'(ax - bx) * longint'(y - by);
                    e2 = longint'(x - cx) * longint'(by - cy) - longint'(bx - cx) * longint'(y - cy);
                    e3 = longint'(x - ax) * longint'(cy - ay) - longint'(cx - ax) * longint'(y - ay);
                    in_pos = (e1 >= 0) && (e2 >= 0) && (e3 >= 0);
                    in_neg = (e1 <= 0) && (e2 <= 0) && (e3 <= 0);
`ifdef TRI_RASTER_BACKFACE_EN
                    if (in_pos || in_neg) begin
`else
                    if (in_pos) begin
`endif
                        sb.push_back({x[W-1:0], y[W-1:0]});
                        cnt++;
                    end
                end
                n++;
            end
        end
        return cnt;
    endfunction

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pixel actual=(%0d,%0d) required=none", out_x, out_y);
                end else begin
                    e = sb.pop_front();
                    if ({out_x, out_y} != e) begin
                        failures++;
                        $display("FAIL pixel actual=(%0d,%0d) required=(%0d,%0d)",
                                 out_x, out_y, e[2*W-1:W], e[W-1:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        done_cnt = 0;
        rst_n = 1'b1;
    endtask

    // Presents a triangle; returns at accept edge + 1.
    task automatic apply_tri(input int ax, input int ay, input int bx,
                             input int by, input int cx, input int cy);
        p1X = ax[W-1:0]; p1Y = ay[W-1:0];
        p2X = bx[W-1:0]; p2Y = by[W-1:0];
        p3X = cx[W-1:0]; p3Y = cy[W-1:0];
        in_valid = 1'b1;
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble vertices: they must only be sampled at acceptance.
        p1X = 12'd3; p1Y = 12'd900; p2X = 12'd1000; p2Y = 12'd1;
        p3X = 12'd55; p3Y = 12'd77;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, done, 1);
        @(posedge clk);
        #1;
        chk({name, "_done_once"}, done_cnt, 1);
        chk({name, "_idle_ready"}, in_ready, 1);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    int cnt;

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        p1X = '0; p1Y = '0; p2X = '0; p2Y = '0; p3X = '0; p3Y = '0;
        #2;
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pix_count", pix_count, 0);
        chk("rst_done", done, 0);

        // Counter-clockwise triangle, free-running consumer (221 pixels).
        done_cnt = 0;
        cnt = model(20, 20, 40, 20, 30, 40, 1 << 30);
        apply_tri(20, 20, 40, 20, 30, 40);
        chk("bbox_cycle_no_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("first_valid", out_valid, 1);
        chk("first_x", out_x, 20);
        chk("first_y", out_y, 20);
        // Busy: a new triangle offer must be ignored.
        p1X = 12'd0; p1Y = 12'd0; p2X = 12'd9; p2Y = 12'd0; p3X = 12'd0; p3Y = 12'd9;
        in_valid = 1'b1;
        chk("busy_not_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done("t1");
        chk("t1_pix_count", pix_count, 221);

        // Same triangle, consumer stalls on the first pixel.
        done_cnt = 0;
        out_ready = 1'b0;
        cnt = model(20, 20, 40, 20, 30, 40, 1 << 30);
        apply_tri(20, 20, 40, 20, 30, 40);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_x", out_x, 20);
            chk("stall_y", out_y, 20);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("after_stall_x", out_x, 21);
        chk("after_stall_y", out_y, 20);
        wait_done("t2");
        chk("t2_pix_count", pix_count, 221);

        // Clockwise winding.
        done_cnt = 0;
        cnt = model(20, 20, 30, 40, 40, 20, 1 << 30);
        apply_tri(20, 20, 30, 40, 40, 20);
        wait_done("t3");
`ifdef TRI_RASTER_BACKFACE_EN
        chk("t3_pix_count", pix_count, 221);
`else
        chk("t3_pix_count", pix_count, 0);
`endif

        // Fully degenerate single-point triangle.
        done_cnt = 0;
        cnt = model(7, 7, 7, 7, 7, 7, 1 << 30);
        apply_tri(7, 7, 7, 7, 7, 7);
        @(posedge clk);
        #1;
        chk("pt_valid", out_valid, 1);
        chk("pt_x", out_x, 7);
        wait_done("t4");
        chk("t4_pix_count", pix_count, 1);

        // Reset mid-scan: first 30 box points give 21 + 8 = 29 pixels.
        done_cnt = 0;
        cnt = model(20, 20, 40, 20, 30, 40, 30);
        apply_tri(20, 20, 40, 20, 30, 40);
        wait_sb_empty("t5_partial", 200);
        chk("t5_pre_rst_count", pix_count, 29);
        chk("t5_pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_count", pix_count, 0);
        chk("t5_rst_x", out_x, 0);
        chk("t5_rst_y", out_y, 0);
        chk("t5_rst_done", done, 0);
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        done_cnt = 0;
        cnt = model(20, 20, 40, 20, 30, 40, 1 << 30);
        apply_tri(20, 20, 40, 20, 30, 40);
        wait_done("t5b");
        chk("t5b_pix_count", pix_count, 221);

        // Full-range triangle: whole first row plus (0,1), then abort.
        done_cnt = 0;
        cnt = model(0, 0, 4095, 0, 0, 4095, 4097);
        apply_tri(0, 0, 4095, 0, 0, 4095);
        wait_sb_empty("t6_row0", 6000);
        chk("t6_count", pix_count, 4097);
        chk("t6_next_valid", out_valid, 1);
        chk("t6_next_x", out_x, 1);
        chk("t6_next_y", out_y, 1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
